// File: rtl/divu_if.sv
// Request/result bundle between the CPU datapath and the sequential divider.
// The datapath uses the master side; the divider, which owns HI/LO, uses the slave side.
interface divu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic             dz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, dividend, divisor,
      input  busy, done, dz, hi, lo
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, dz, hi, lo
   );
endinterface

// File: rtl/divu_seq.sv
// Restoring unsigned divider for DIVU, one quotient bit per cycle; owns HI (remainder) and LO (quotient).
// A zero divisor short-circuits straight to DONE with lo = all ones, hi = dividend, dz = 1.
module divu_seq #(
   parameter int WIDTH = 32
) (
   input logic   clk,
   input logic   rst,
   divu_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] rem_reg, rem_next;
   logic [WIDTH-1:0] quo_reg, quo_next;
   logic [WIDTH-1:0] dvs_reg, dvs_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic             dz_reg, dz_next;

   // One restoring step; the compare is WIDTH+1 bits so a shifted-out MSB is never lost.
   logic [WIDTH:0]   t_hi;
   logic             ge;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;

   always_comb begin
      t_hi     = {rem_reg, quo_reg[WIDTH-1]};
      ge       = (t_hi >= {1'b0, dvs_reg});
      rem_step = ge ? (t_hi[WIDTH-1:0] - dvs_reg) : t_hi[WIDTH-1:0];
      quo_step = {quo_reg[WIDTH-2:0], ge};
   end

   always_comb begin
      state_next = state_reg;
      rem_next   = rem_reg;
      quo_next   = quo_reg;
      dvs_next   = dvs_reg;
      cnt_next   = cnt_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      dz_next    = dz_reg;

      case (state_reg)
         RUN: begin
            rem_next = rem_step;
            quo_next = quo_step;
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
               state_next = DONE;
               hi_next    = rem_step;
               lo_next    = quo_step;
               dz_next    = 1'b0;
            end
         end
         default: begin
            // IDLE and DONE accept a new request identically, enabling back-to-back ops.
            state_next = IDLE;
            if (bus.start) begin
               if (bus.divisor != '0) begin
                  state_next = RUN;
                  rem_next   = '0;
                  quo_next   = bus.dividend;
                  dvs_next   = bus.divisor;
                  cnt_next   = CW'(WIDTH);
               end else begin
                  state_next = DONE;
                  hi_next    = bus.dividend;
                  lo_next    = '1;
                  dz_next    = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         rem_reg   <= '0;
         quo_reg   <= '0;
         dvs_reg   <= '0;
         cnt_reg   <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         dz_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         rem_reg   <= rem_next;
         quo_reg   <= quo_next;
         dvs_reg   <= dvs_next;
         cnt_reg   <= cnt_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
         dz_reg    <= dz_next;
      end
   end

   assign bus.busy = (state_reg == RUN);
   assign bus.done = (state_reg == DONE);
   assign bus.dz   = dz_reg;
   assign bus.hi   = hi_reg;
   assign bus.lo   = lo_reg;
endmodule
